// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment bytes are active-low and ordered {dp,g,f,e,d,c,b,a}.
package bcd_scan_display_pkg;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam int         DP_BIT    = 7;
   localparam logic [7:0] DIGIT_PAT [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; values above 9
// render as a minus sign so a corrupt upstream digit is visible.
import bcd_scan_display_pkg::*;

module bcd_to_seg7 (
   input  logic [3:0] val_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = SEG_BLANK[6:0];
      if (!blank_i) begin
         if (val_i > 4'd9) seg_o = SEG_MINUS[6:0];
         else              seg_o = DIGIT_PAT[val_i][6:0];
      end
   end
endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode display scanner with frame snapshot,
// anti-ghost blanking, leading-zero suppression and carry dp flash.
import bcd_scan_display_pkg::*;

module bcd_scan_display #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 2,
   parameter int FLASH_FRAMES = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic                  lz_en,
   input  logic                  flash,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg,
   output logic                  frame
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam int FW = $clog2(FLASH_FRAMES + 1);

   logic [DW-1:0]            div_cnt_q, div_cnt_d;
   logic [IW-1:0]            digit_idx_q, digit_idx_d;
   logic [DIGITS-1:0][3:0]   snap_q, snap_d;
   logic [FW-1:0]            flash_cnt_q, flash_cnt_d;
   logic [DIGITS-1:0]        an_q, an_d;
   logic [7:0]               seg_q, seg_d;
   logic                     frame_q, frame_d;

   logic                     slot_end, frame_wrap;
   logic [DIGITS-1:0]        lz_blank;
   logic [6:0]               dec_seg;

   assign slot_end   = (div_cnt_q == DW'(SCAN_DIV - 1));
   assign frame_wrap = slot_end && (digit_idx_q == IW'(DIGITS - 1));

   always_comb begin
      div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
      digit_idx_d = digit_idx_q;
      if (slot_end)
         digit_idx_d = (digit_idx_q == IW'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
      snap_d  = frame_wrap ? bcd : snap_q;
      frame_d = frame_wrap;
      // A fresh carry wins over the frame-wrap decrement so the flash restarts.
      flash_cnt_d = flash_cnt_q;
      if (flash)
         flash_cnt_d = FW'(FLASH_FRAMES);
      else if (frame_wrap && (flash_cnt_q != '0))
         flash_cnt_d = flash_cnt_q - 1'b1;
   end

   // Walk from the most significant digit down; stop blanking at the first
   // nonzero (invalid codes count as nonzero). Digit 0 always shows.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lz_blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         all_zero    = all_zero && (snap_q[k] == 4'd0);
         lz_blank[k] = lz_en && all_zero && (k != 0);
      end
   end

   bcd_to_seg7 u_dec (
      .val_i   (snap_q[digit_idx_q]),
      .blank_i (lz_blank[digit_idx_q]),
      .seg_o   (dec_seg)
   );

   always_comb begin
      an_d = '1;
      if (div_cnt_q >= DW'(BLANK_CYC)) an_d[digit_idx_q] = 1'b0;
      seg_d         = {1'b1, dec_seg};
      seg_d[DP_BIT] = (flash_cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q   <= '0;
         digit_idx_q <= '0;
         snap_q      <= '0;
         flash_cnt_q <= '0;
         an_q        <= '1;
         seg_q       <= SEG_BLANK;
         frame_q     <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         digit_idx_q <= digit_idx_d;
         snap_q      <= snap_d;
         flash_cnt_q <= flash_cnt_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         frame_q     <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign frame = frame_q;
endmodule
